bus_arbiter: RTL and testbench

Shares the single internal 32-bit cart bus between three masters: N64 PI, PC link, and an internal DMA engine. It latches single-cycle request pulses, grants one master at a time by fixed priority, and drives the shared bus strobes, address and write data. It routes the bus acknowledge and read data back to the owner. It sits between the masters and the address decoder / slave modules, and replaces the ad-hoc `n64_disable` mux at top level.

---
 rtl/bus_arbiter_if.sv | 54 +++++
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master/PC/DMA request, cart bus and status signals of bus_arbiter
interface bus_arbiter_if;
  logic        i_n64_disable;
  logic        i_n64_read_rq;
  logic        i_n64_write_rq;
  logic [31:0] i_n64_address;
  logic [31:0] i_n64_data;
  logic        o_n64_ack;

  logic        i_pc_read_rq;
  logic        i_pc_write_rq;
  logic [31:0] i_pc_address;
  logic [31:0] i_pc_data;
  logic        o_pc_ack;

  logic        i_dma_read_rq;
  logic        i_dma_write_rq;
  logic [31:0] i_dma_address;
  logic [31:0] i_dma_data;
  logic        o_dma_ack;

  logic [31:0] o_data;
  logic        o_bus_read_rq;
  logic        o_bus_write_rq;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_data;
  logic        i_bus_ack;
  logic [31:0] i_bus_data;
  logic [1:0]  o_owner;
  logic        o_bus_active;
  logic        o_timeout;

  // Arbiter side: it masters the shared cart bus.
  modport master (
    input  i_n64_disable, i_n64_read_rq, i_n64_write_rq, i_n64_address, i_n64_data,
    input  i_pc_read_rq, i_pc_write_rq, i_pc_address, i_pc_data,
    input  i_dma_read_rq, i_dma_write_rq, i_dma_address, i_dma_data,
    input  i_bus_ack, i_bus_data,
    output o_n64_ack, o_pc_ack, o_dma_ack, o_data,
    output o_bus_read_rq, o_bus_write_rq, o_bus_address, o_bus_data,
    output o_owner, o_bus_active, o_timeout
  );

  // Surrounding side: requesting masters plus the slave decoder.
  modport slave (
    output i_n64_disable, i_n64_read_rq, i_n64_write_rq, i_n64_address, i_n64_data,
    output i_pc_read_rq, i_pc_write_rq, i_pc_address, i_pc_data,
    output i_dma_read_rq, i_dma_write_rq, i_dma_address, i_dma_data,
    output i_bus_ack, i_bus_data,
    input  o_n64_ack, o_pc_ack, o_dma_ack, o_data,
    input  o_bus_read_rq, o_bus_write_rq, o_bus_address, o_bus_data,
    input  o_owner, o_bus_active, o_timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - fixed-priority (N64 > PC > DMA) arbiter for the shared 32-bit cart bus
// Optional WAIT timeout with synthetic ack: define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  pend_q, wr_q;
  logic [2:0]  rd_rq, wr_rq, eligible, owner_oh;
  logic [1:0]  owner_q, grant, owner;
  logic        done, tmo_fire, owner_wr;

  // Bit order everywhere: [0] N64, [1] PC, [2] DMA.
  assign rd_rq    = {bus.i_dma_read_rq,  bus.i_pc_read_rq,  bus.i_n64_read_rq};
  assign wr_rq    = {bus.i_dma_write_rq, bus.i_pc_write_rq, bus.i_n64_write_rq};
  assign eligible = {pend_q[2], pend_q[1], pend_q[0] & ~bus.i_n64_disable};

  always_comb begin
    grant = 2'd0;
    if (eligible[0])      grant = 2'd1;
    else if (eligible[1]) grant = 2'd2;
    else if (eligible[2]) grant = 2'd3;
  end

  // The grant is visible in the IDLE cycle it is decided, then held in owner_q.
  assign owner = (state_q == ST_IDLE) ? grant : owner_q;

  always_comb begin
    owner_oh = 3'b000;
    case (owner)
      2'd1:    owner_oh = 3'b001;
      2'd2:    owner_oh = 3'b010;
      2'd3:    owner_oh = 3'b100;
      default: owner_oh = 3'b000;
    endcase
  end

  assign owner_wr = |(wr_q & owner_oh);

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_cnt_q <= 16'd0;
    end else if (state_q == ST_ISSUE) begin
      tmo_cnt_q <= 16'd0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  // A real slave ack in the same cycle wins over the synthetic one.
  assign tmo_fire = (state_q == ST_WAIT) && !bus.i_bus_ack && (tmo_cnt_q == TMO_LAST);
`else
  logic unused_timeout_param;
  assign unused_timeout_param = |16'(TIMEOUT);
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'd0) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.i_bus_ack) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.i_bus_ack || tmo_fire) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner;
    end
  end

  // A master that is pending (owner included) ignores further rq pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend_q <= 3'b000;
      wr_q   <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (done && owner_oh[i]) begin
          pend_q[i] <= 1'b0;
        end else if (!pend_q[i] && (rd_rq[i] || wr_rq[i])) begin
          pend_q[i] <= 1'b1;
          wr_q[i]   <= wr_rq[i];
        end
      end
    end
  end

  always_comb begin
    bus.o_bus_address = 32'd0;
    bus.o_bus_data    = 32'd0;
    case (owner)
      2'd1: begin
        bus.o_bus_address = bus.i_n64_address;
        bus.o_bus_data    = bus.i_n64_data;
      end
      2'd2: begin
        bus.o_bus_address = bus.i_pc_address;
        bus.o_bus_data    = bus.i_pc_data;
      end
      2'd3: begin
        bus.o_bus_address = bus.i_dma_address;
        bus.o_bus_data    = bus.i_dma_data;
      end
      default: begin
        bus.o_bus_address = 32'd0;
        bus.o_bus_data    = 32'd0;
      end
    endcase
  end

  assign bus.o_owner        = owner;
  assign bus.o_bus_active   = (state_q != ST_IDLE);
  assign bus.o_bus_read_rq  = (state_q == ST_ISSUE) && !owner_wr;
  assign bus.o_bus_write_rq = (state_q == ST_ISSUE) && owner_wr;
  assign bus.o_n64_ack      = done && owner_oh[0];
  assign bus.o_pc_ack       = done && owner_oh[1];
  assign bus.o_dma_ack      = done && owner_oh[2];
  assign bus.o_timeout      = tmo_fire;
  assign bus.o_data         = !done          ? 32'd0 :
                              bus.i_bus_ack  ? bus.i_bus_data : 32'hFFFF_FFFF;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector table plus reset/timeout sequences for bus_arbiter
module tb_bus_arbiter;

  localparam logic [31:0] N64_A = 32'h1000_0040, N64_D = 32'hA1A1_0001;
  localparam logic [31:0] PC_A  = 32'h1FFE_0008, PC_D  = 32'hB2B2_0002;
  localparam logic [31:0] DMA_A = 32'h0400_1000, DMA_D = 32'hC3C3_0003;

  localparam logic [5:0] N64R = 6'b000001, N64W = 6'b000010;
  localparam logic [5:0] PCR  = 6'b000100, PCW  = 6'b001000;
  localparam logic [5:0] DMAR = 6'b010000, DMAW = 6'b100000;

  typedef struct {
    logic        dis;
    logic [5:0]  rq;      // {dma_wr, dma_rd, pc_wr, pc_rd, n64_wr, n64_rd}
    logic        ack;
    logic [31:0] bdata;
    logic [1:0]  owner;
    logic [1:0]  strobe;  // {write, read}
    logic [2:0]  acks;    // {dma, pc, n64}
    logic        active;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT(8)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bif)
  );

  function automatic vec_t mk(logic dis, logic [5:0] rq, logic ack, logic [31:0] bdata,
                              logic [1:0] owner, logic [1:0] strobe, logic [2:0] acks,
                              logic active, logic [31:0] data);
    vec_t v;
    v.dis = dis; v.rq = rq; v.ack = ack; v.bdata = bdata;
    v.owner = owner; v.strobe = strobe; v.acks = acks; v.active = active; v.data = data;
    return v;
  endfunction

  function automatic logic [31:0] addr_of(logic [1:0] o);
    case (o)
      2'd1:    return N64_A;
      2'd2:    return PC_A;
      2'd3:    return DMA_A;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(logic [1:0] o);
    case (o)
      2'd1:    return N64_D;
      2'd2:    return PC_D;
      2'd3:    return DMA_D;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [104:0] got_vec();
    return {bif.o_owner, bif.o_bus_write_rq, bif.o_bus_read_rq,
            bif.o_dma_ack, bif.o_pc_ack, bif.o_n64_ack, bif.o_bus_active, bif.o_timeout,
            bif.o_data, bif.o_bus_address, bif.o_bus_data};
  endfunction

  task automatic check(input string name, input logic [104:0] got, input logic [104:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic dis, input logic [5:0] rq, input logic ack, input logic [31:0] bdata);
    bif.i_n64_disable  = dis;
    bif.i_n64_read_rq  = rq[0];
    bif.i_n64_write_rq = rq[1];
    bif.i_pc_read_rq   = rq[2];
    bif.i_pc_write_rq  = rq[3];
    bif.i_dma_read_rq  = rq[4];
    bif.i_dma_write_rq = rq[5];
    bif.i_bus_ack      = ack;
    bif.i_bus_data     = bdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [104:0] exp;
    int           hit;
    int           seen;
    logic [31:0]  tdata;
    logic         ttmo;

    bif.i_n64_address = N64_A; bif.i_n64_data = N64_D;
    bif.i_pc_address  = PC_A;  bif.i_pc_data  = PC_D;
    bif.i_dma_address = DMA_A; bif.i_dma_data = DMA_D;
    drive(1'b0, 6'd0, 1'b1, 32'h9999_9999);

    // N64 read, slave acks in cycle 4
    vecs.push_back(mk(0, N64R, 0, 0,             0, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             1, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             1, 2'b01, 3'b000, 1, 0));
    vecs.push_back(mk(0, 0,    0, 0,             1, 2'b00, 3'b000, 1, 0));
    vecs.push_back(mk(0, 0,    1, 32'h1234_5678, 1, 2'b00, 3'b001, 1, 32'h1234_5678));
    vecs.push_back(mk(0, 0,    0, 0,             0, 2'b00, 3'b000, 0, 0));
    // simultaneous PC write + DMA read
    vecs.push_back(mk(0, PCW | DMAR, 0, 0,       0, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             2, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             2, 2'b10, 3'b000, 1, 0));
    vecs.push_back(mk(0, 0,    0, 0,             2, 2'b00, 3'b000, 1, 0));
    vecs.push_back(mk(0, 0,    1, 32'hDEAD_BEEF, 2, 2'b00, 3'b010, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 0,    0, 0,             3, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             3, 2'b01, 3'b000, 1, 0));
    vecs.push_back(mk(0, 0,    0, 0,             3, 2'b00, 3'b000, 1, 0));
    vecs.push_back(mk(0, 0,    1, 32'hCAFE_0001, 3, 2'b00, 3'b100, 1, 32'hCAFE_0001));
    vecs.push_back(mk(0, 0,    0, 0,             0, 2'b00, 3'b000, 0, 0));
    // N64 masked while PC is served; idle-state ack ignored; no preemption on disable
    vecs.push_back(mk(1, N64R | PCR, 0, 0,       0, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(1, 0,    0, 0,             2, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(1, 0,    0, 0,             2, 2'b01, 3'b000, 1, 0));
    vecs.push_back(mk(1, 0,    1, 32'h1111_0000, 2, 2'b00, 3'b010, 1, 32'h1111_0000));
    vecs.push_back(mk(1, 0,    1, 32'h2222_0000, 0, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(1, 0,    0, 0,             0, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             1, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(1, 0,    0, 0,             1, 2'b01, 3'b000, 1, 0));
    vecs.push_back(mk(1, 0,    1, 32'h3333_0000, 1, 2'b00, 3'b001, 1, 32'h3333_0000));
    vecs.push_back(mk(0, 0,    0, 0,             0, 2'b00, 3'b000, 0, 0));
    // read+write together -> write; duplicate pulses while owner are dropped
    vecs.push_back(mk(0, N64R | N64W, 0, 0,      0, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             1, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, N64R, 0, 0,             1, 2'b10, 3'b000, 1, 0));
    vecs.push_back(mk(0, N64W, 0, 0,             1, 2'b00, 3'b000, 1, 0));
    vecs.push_back(mk(0, N64R, 1, 32'h4444_0000, 1, 2'b00, 3'b001, 1, 32'h4444_0000));
    vecs.push_back(mk(0, 0,    0, 0,             0, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             0, 2'b00, 3'b000, 0, 0));
    // ack in ISSUE, then minimum turnaround to the next grant
    vecs.push_back(mk(0, DMAW, 0, 0,             0, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             3, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, PCR,  1, 32'h5555_0000, 3, 2'b10, 3'b100, 1, 32'h5555_0000));
    vecs.push_back(mk(0, 0,    0, 0,             2, 2'b00, 3'b000, 0, 0));
    vecs.push_back(mk(0, 0,    0, 0,             2, 2'b01, 3'b000, 1, 0));
    vecs.push_back(mk(0, 0,    1, 32'h6666_0000, 2, 2'b00, 3'b010, 1, 32'h6666_0000));
    vecs.push_back(mk(0, 0,    0, 0,             0, 2'b00, 3'b000, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", got_vec(), 105'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].dis, vecs[i].rq, vecs[i].ack, vecs[i].bdata);
      @(negedge clk);
      exp = {vecs[i].owner, vecs[i].strobe, vecs[i].acks, vecs[i].active, 1'b0,
             vecs[i].data, addr_of(vecs[i].owner), wdata_of(vecs[i].owner)};
      check($sformatf("vec%0d", i), got_vec(), exp);
      tick();
    end

    // reset asserted while PC owns the bus in WAIT
    drive(1'b0, PCR, 1'b0, 32'd0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("pc_in_wait", {103'd0, bif.o_bus_active, bif.o_owner == 2'd2}, {103'd0, 2'b11});
    #2;
    bif.i_bus_ack  = 1'b1;
    bif.i_bus_data = 32'hAAAA_5555;
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait", got_vec(), 105'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bif.o_owner != 2'd0 || bif.o_n64_ack || bif.o_pc_ack || bif.o_dma_ack ||
          bif.o_bus_read_rq || bif.o_bus_write_rq || bif.o_bus_active)
        seen++;
      tick();
      bif.i_bus_ack = 1'b0;
    end
    check("after_reset_quiet", 105'(seen), 105'd0);

    // DMA read with no slave ack
    drive(1'b0, DMAR, 1'b0, 32'd0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 32'd0);
`ifdef BUS_ARBITER_TIMEOUT_EN
    seen = 0; hit = 0; tdata = 32'd0; ttmo = 1'b0;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      @(negedge clk);
      if (bif.o_timeout && !bif.o_dma_ack) hit = -1;
      if (bif.o_dma_ack) begin
        seen = 1;
        if (hit == 0) hit = k;
        tdata = bif.o_data;
        ttmo  = bif.o_timeout;
      end
      tick();
    end
    check("tmo_ack_cycle", 105'(hit), 105'd10);
    check("tmo_data_flag", {72'd0, tdata, ttmo}, {72'd0, 32'hFFFF_FFFF, 1'b1});
    drive(1'b0, PCR, 1'b0, 32'd0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    tick();
    tick();
    drive(1'b0, 6'd0, 1'b1, 32'h7777_0000);
    @(negedge clk);
    check("pc_after_tmo", {71'd0, bif.o_pc_ack, bif.o_timeout, bif.o_data},
          {71'd0, 1'b1, 1'b0, 32'h7777_0000});
    tick();
    drive(1'b0, 6'd0, 1'b0, 32'd0);
`else
    seen = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bif.o_dma_ack || bif.o_timeout) seen++;
      tick();
    end
    check("no_tmo_still_waiting", {103'd0, bif.o_bus_active, seen == 0}, {103'd0, 2'b11});
    drive(1'b0, 6'd0, 1'b1, 32'h7777_0000);
    @(negedge clk);
    check("late_ack", {71'd0, bif.o_dma_ack, bif.o_timeout, bif.o_data},
          {71'd0, 1'b1, 1'b0, 32'h7777_0000});
    tick();
    drive(1'b0, 6'd0, 1'b0, 32'd0);
    hit = 0;
    ttmo = 1'b0;
    tdata = 32'd0;
`endif
    @(negedge clk);
    check("final_idle", {102'd0, bif.o_owner, bif.o_bus_active}, 105'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
